fill_arbiter_nch: RTL and testbench

//   Parametrised N-channel arbiter feeding the DRAM-cache fill FIFO. Generalises the two-input

---
 rtl/fill_arbiter_nch.sv | 77 +++++++
 tb/tb_fill_arbiter_nch.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fill_arbiter_nch.sv
// fill_arbiter_nch: N-channel round-robin / aged-priority arbiter into the fill FIFO write port.
module fill_arbiter_nch #(
  parameter int NUM_CH        = 2,
  parameter int PAYLOAD_WIDTH = 96,
  parameter int MODE          = 0,
  parameter int AGE_LIMIT     = 15,
  localparam int CH_W         = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CH-1:0]                 req_valid_i,
  output logic [NUM_CH-1:0]                 req_ready_o,
  input  logic [NUM_CH*PAYLOAD_WIDTH-1:0]   req_data_i,
  input  logic                              fifo_afull_i,
  output logic                              fifo_wren_o,
  output logic [PAYLOAD_WIDTH-1:0]          fifo_data_o,
  output logic [CH_W-1:0]                   fifo_ch_o,
  output logic [NUM_CH-1:0]                 starve_o
);
  logic [CH_W-1:0]          rr_q, rr_d, g, ch_q;
  logic                     any, acc, wren_q;
  logic [NUM_CH-1:0][7:0]   age_q, age_d;
  logic [NUM_CH-1:0]        starve_q, starve_d;
  logic [PAYLOAD_WIDTH-1:0] data_q;
  // Scan downward so the highest-priority candidate is the last one written.
  always_comb begin
    g   = '0;
    any = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      int idx;
      idx = MODE == 0 ? (int'(rr_q) + i) % NUM_CH : i;
      if (req_valid_i[idx]) begin
        g   = CH_W'(idx);
        any = 1'b1;
      end
    end
    if (MODE != 0)
      for (int i = NUM_CH - 1; i >= 0; i--)
        if (req_valid_i[i] && age_q[i] == 8'(AGE_LIMIT)) g = CH_W'(i);
  end
  assign acc         = any && !fifo_afull_i;
  assign req_ready_o = (rst_n && acc) ? NUM_CH'(1) << g : '0;
  assign rr_d        = acc ? ((g == CH_W'(NUM_CH - 1)) ? '0 : g + 1'b1) : rr_q;
  // Ages freeze under backpressure so a blocked channel keeps its seniority.
  always_comb begin
    age_d    = age_q;
    starve_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (MODE != 0)
        age_d[k] = fifo_afull_i ? age_q[k] :
                   (!req_valid_i[k] || (acc && g == CH_W'(k))) ? 8'd0 :
                   (acc && age_q[k] < 8'(AGE_LIMIT)) ? age_q[k] + 8'd1 : age_q[k];
      starve_d[k] = MODE != 0 && age_d[k] == 8'(AGE_LIMIT);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q     <= '0;
      age_q    <= '0;
      starve_q <= '0;
      wren_q   <= 1'b0;
      data_q   <= '0;
      ch_q     <= '0;
    end else begin
      rr_q     <= rr_d;
      age_q    <= age_d;
      starve_q <= starve_d;
      wren_q   <= acc;
      data_q   <= acc ? req_data_i[int'(g)*PAYLOAD_WIDTH +: PAYLOAD_WIDTH] : data_q;
      ch_q     <= acc ? g : ch_q;
    end
  end
  assign fifo_wren_o = wren_q;
  assign fifo_data_o = data_q;
  assign fifo_ch_o   = ch_q;
  assign starve_o    = starve_q;
endmodule

// File: tb/tb_fill_arbiter_nch.sv
// tb_fill_arbiter_nch: directed checks of round-robin, aged priority, backpressure, reset and single-channel use.
module tb_fill_arbiter_nch;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  va, ra, sa;
  logic [63:0] da;
  logic        afa, wa;
  logic [15:0] fda;
  logic [1:0]  cha;

  logic [1:0]  vb, rb, sb;
  logic [31:0] db;
  logic        afb, wb;
  logic [15:0] fdb;
  logic [0:0]  chb;

  logic [0:0]  vc, rc, sc;
  logic [15:0] dc, fdc;
  logic        afc, wc;
  logic [0:0]  chc;

  int n_chk = 0;
  int n_fail = 0;
  int writes;

  fill_arbiter_nch #(.NUM_CH(4), .PAYLOAD_WIDTH(16), .MODE(0), .AGE_LIMIT(15)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid_i(va), .req_ready_o(ra), .req_data_i(da),
    .fifo_afull_i(afa), .fifo_wren_o(wa), .fifo_data_o(fda), .fifo_ch_o(cha), .starve_o(sa));

  fill_arbiter_nch #(.NUM_CH(2), .PAYLOAD_WIDTH(16), .MODE(1), .AGE_LIMIT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid_i(vb), .req_ready_o(rb), .req_data_i(db),
    .fifo_afull_i(afb), .fifo_wren_o(wb), .fifo_data_o(fdb), .fifo_ch_o(chb), .starve_o(sb));

  fill_arbiter_nch #(.NUM_CH(1), .PAYLOAD_WIDTH(16), .MODE(0), .AGE_LIMIT(15)) u_c (
    .clk(clk), .rst_n(rst_n), .req_valid_i(vc), .req_ready_o(rc), .req_data_i(dc),
    .fifo_afull_i(afc), .fifo_wren_o(wc), .fifo_data_o(fdc), .fifo_ch_o(chc), .starve_o(sc));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    va = '0; afa = 1'b0; da = {16'h103, 16'h102, 16'h101, 16'h100};
    vb = '0; afb = 1'b0; db = {16'h201, 16'h200};
    vc = '0; afc = 1'b0; dc = 16'h300;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wren", wa, 0);
    chk("rst_data", fda, 0);
    chk("rst_ch", cha, 0);
    chk("rst_ready", ra, 0);
    chk("rst_starve_a", sa, 0);
    chk("rst_starve_b", sb, 0);
    chk("rst_wren_c", wc, 0);
    rst_n = 1'b1;

    va = 4'hF;
    for (int i = 0; i < 8; i++) begin
      step;
      chk("t1_wren", wa, 1);
      chk("t1_ch", cha, i % 4);
      chk("t1_data", fda, 16'h100 + i % 4);
    end
    va = '0;
    step;
    chk("t1_idle_wren", wa, 0);
    chk("t1_hold_data", fda, 16'h103);
    chk("t1_hold_ch", cha, 3);

    va = 4'b0100;
    #1 chk("t2_ready_a", ra, 4'b0100);
    step;
    chk("t2_ch_a", cha, 2);
    da[47:32] = 16'hABC;
    #1 chk("t2_ready_b", ra, 4'b0100);
    step;
    chk("t2_ch_b", cha, 2);
    chk("t2_data", fda, 16'hABC);
    chk("t2_wren", wa, 1);
    va = 4'hF;
    #1 chk("t2_rrptr", ra, 4'b1000);
    va = '0;
    step;

    va = 4'b0011;
    afa = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t3_ready_afull", ra, 0);
      step;
      chk("t3_wren_afull", wa, 0);
    end
    afa = 1'b0;
    #1 chk("t3_ready_ch0", ra, 4'b0001);
    step;
    chk("t3_wren0", wa, 1);
    chk("t3_ch0", cha, 0);
    #1 chk("t3_ready_ch1", ra, 4'b0010);
    step;
    chk("t3_ch1", cha, 1);
    chk("t3_data1", fda, 16'h101);
    va = '0;
    step;

    vb = 2'b11;
    for (int c = 0; c < 8; c++) begin
      #1 chk("t4_starve", sb, (c % 4 == 3) ? 2'b10 : 2'b00);
      chk("t4_ready", rb, (c % 4 == 3) ? 2'b10 : 2'b01);
      step;
      chk("t4_ch", chb, (c % 4 == 3) ? 1 : 0);
      chk("t4_data", fdb, (c % 4 == 3) ? 16'h201 : 16'h200);
    end
    vb = '0;
    step;

    va = 4'hF;
    step;
    chk("t5_pre_ch", cha, 2);
    step;
    step;
    chk("t5_pre_ch0", cha, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_async_wren", wa, 0);
    chk("t5_async_data", fda, 0);
    chk("t5_async_ch", cha, 0);
    chk("t5_async_ready", ra, 0);
    step;
    chk("t5_held_wren", wa, 0);
    rst_n = 1'b1;
    #1 chk("t5_restart_ready", ra, 4'b0001);
    step;
    chk("t5_restart_wren", wa, 1);
    chk("t5_restart_ch", cha, 0);
    step;
    chk("t5_next_ch", cha, 1);
    va = '0;
    step;
    chk("t5_idle_wren", wa, 0);

    vc = 1'b1;
    writes = 0;
    for (int c = 0; c < 10; c++) begin
      afc = c[0];
      #1 chk("t6_ready", rc, !afc);
      step;
      chk("t6_wren", wc, !afc);
      writes += int'(wc);
    end
    vc = '0;
    afc = 1'b0;
    step;
    chk("t6_writes", writes, 5);
    chk("t6_ch", chc, 0);
    chk("t6_idle_wren", wc, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
